// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1331 power-up sequencer:
// FSM states, command-table entry layout, DC modes and panel opcodes.
package oled_pkg;

    localparam int unsigned TBL_WORD_W  = 10;
    localparam int unsigned TBL_DELAY_W = 16;
    localparam int unsigned TBL_DEPTH   = 16;

    localparam logic [1:0] DC_CMD  = 2'b00;
    localparam logic [1:0] DC_DAT  = 2'b01;
    localparam logic [1:0] DC_IDLE = 2'b11;

    localparam logic [7:0] OP_DISPLAY_OFF    = 8'hAE;
    localparam logic [7:0] OP_CONTRAST_A     = 8'h81;
    localparam logic [7:0] OP_CONTRAST_B     = 8'h82;
    localparam logic [7:0] OP_CONTRAST_C     = 8'h83;
    localparam logic [7:0] OP_MASTER_CURRENT = 8'h87;
    localparam logic [7:0] OP_PRECHARGE_A    = 8'h8A;
    localparam logic [7:0] OP_PRECHARGE_B    = 8'h8B;
    localparam logic [7:0] OP_PRECHARGE_C    = 8'h8C;
    localparam logic [7:0] OP_DISPLAY_ON     = 8'hAF;
    localparam logic [7:0] OP_NOP            = 8'hE3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_ASSERT,
        ST_RST_WAIT,
        ST_LOAD,
        ST_WRITE,
        ST_DELAY,
        ST_FINISH
    } oled_state_t;

    typedef struct packed {
        logic [TBL_DELAY_W-1:0] delay;
        logic [TBL_WORD_W-1:0]  word;
    } init_entry_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic init_entry_t mk_cmd(input logic [7:0] op, input logic [TBL_DELAY_W-1:0] dly);
        init_entry_t e;
        e.delay = dly;
        e.word  = {DC_CMD, op};
        return e;
    endfunction

endpackage

// File: rtl/oled_init_rom.sv
// Combinational power-up command table: index -> {post-write delay, SPI word}.
// Indices past the table return a zero-delay NOP so oversized NUM_CMDS stays harmless.
module oled_init_rom
    import oled_pkg::*;
(
    input  logic [7:0]  idx,
    output init_entry_t entry
);

    localparam logic [TBL_DELAY_W-1:0] PWR_DELAY = TBL_DELAY_W'(100);
    localparam logic [TBL_DELAY_W-1:0] NO_DELAY  = '0;

    always_comb begin
        entry = mk_cmd(OP_NOP, NO_DELAY);
        case (idx)
            8'd0:    entry = mk_cmd(OP_DISPLAY_OFF,    PWR_DELAY);
            8'd1:    entry = mk_cmd(OP_CONTRAST_A,     NO_DELAY);
            8'd2:    entry = mk_cmd(8'hFF,             NO_DELAY);
            8'd3:    entry = mk_cmd(OP_CONTRAST_B,     NO_DELAY);
            8'd4:    entry = mk_cmd(8'hFF,             NO_DELAY);
            8'd5:    entry = mk_cmd(OP_CONTRAST_C,     NO_DELAY);
            8'd6:    entry = mk_cmd(8'hFF,             NO_DELAY);
            8'd7:    entry = mk_cmd(OP_MASTER_CURRENT, NO_DELAY);
            8'd8:    entry = mk_cmd(8'h06,             NO_DELAY);
            8'd9:    entry = mk_cmd(OP_PRECHARGE_A,    NO_DELAY);
            8'd10:   entry = mk_cmd(8'h64,             NO_DELAY);
            8'd11:   entry = mk_cmd(OP_PRECHARGE_B,    NO_DELAY);
            8'd12:   entry = mk_cmd(8'h78,             NO_DELAY);
            8'd13:   entry = mk_cmd(OP_PRECHARGE_C,    NO_DELAY);
            8'd14:   entry = mk_cmd(8'h64,             NO_DELAY);
            8'd15:   entry = mk_cmd(OP_DISPLAY_ON,     PWR_DELAY);
            default: entry = mk_cmd(OP_NOP,            NO_DELAY);
        endcase
    end

endmodule

// File: rtl/oled_init_sequencer.sv
// OLED power-up sequencer: pulses the panel hard reset, waits for settle,
// then streams the command table through the SPI writer handshake and raises DONE.
module oled_init_sequencer
    import oled_pkg::*;
#(
    parameter int unsigned RST_LOW_CYCLES  = 1000000,
    parameter int unsigned RST_WAIT_CYCLES = 1000,
    parameter int unsigned NUM_CMDS        = 16,
    parameter int unsigned WORD_W          = 10,
    parameter int unsigned DELAY_W         = 16,
    parameter logic [WORD_W-1:0] IDLE_WORD = WORD_W'({DC_IDLE, 8'h00})
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              WRITE_START,
    input  logic              WRITE_DONE,
    output logic [WORD_W-1:0] DATA,
    output logic              RST_OLED
);

    localparam int unsigned IDX_W = width_for(NUM_CMDS - 1);
    localparam int unsigned CNT_W = max_u(max_u(width_for(RST_LOW_CYCLES),
                                                width_for(RST_WAIT_CYCLES)), DELAY_W);

    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_CMDS - 1);
    localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(RST_LOW_CYCLES - 1);
    // A zero settle time still spends one cycle in RST_WAIT.
    localparam logic [CNT_W-1:0] RST_WAIT_LAST = CNT_W'((RST_WAIT_CYCLES == 0) ? 0 : RST_WAIT_CYCLES - 1);

    oled_state_t       state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic              busy_nxt, done_nxt, ws_nxt, rst_oled_nxt;
    logic [WORD_W-1:0] data_nxt;
    logic              advance;

    init_entry_t       entry;
    logic [WORD_W-1:0] entry_word;
    logic [DELAY_W-1:0] entry_delay;

    oled_init_rom u_rom (
        .idx   (8'(idx)),
        .entry (entry)
    );

    assign entry_word  = WORD_W'(entry.word);
    assign entry_delay = DELAY_W'(entry.delay);

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            idx         <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            WRITE_START <= 1'b0;
            DATA        <= IDLE_WORD;
            RST_OLED    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            BUSY        <= busy_nxt;
            DONE        <= done_nxt;
            WRITE_START <= ws_nxt;
            DATA        <= data_nxt;
            RST_OLED    <= rst_oled_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        busy_nxt     = BUSY;
        done_nxt     = DONE;
        ws_nxt       = WRITE_START;
        data_nxt     = DATA;
        rst_oled_nxt = RST_OLED;
        advance      = 1'b0;

        case (state)
            ST_IDLE, ST_FINISH: begin
                if (START) begin
                    state_nxt    = ST_RST_ASSERT;
                    cnt_nxt      = '0;
                    idx_nxt      = '0;
                    done_nxt     = 1'b0;
                    busy_nxt     = 1'b1;
                    rst_oled_nxt = 1'b0;
                end
            end
            ST_RST_ASSERT: begin
                if (cnt == RST_LOW_LAST) begin
                    state_nxt    = ST_RST_WAIT;
                    cnt_nxt      = '0;
                    rst_oled_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RST_WAIT: begin
                if (cnt == RST_WAIT_LAST) begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                state_nxt = ST_WRITE;
                ws_nxt    = 1'b1;
                data_nxt  = entry_word;
            end
            ST_WRITE: begin
                if (WRITE_DONE) begin
                    ws_nxt   = 1'b0;
                    data_nxt = IDLE_WORD;
                    if (entry_delay != '0) begin
                        state_nxt = ST_DELAY;
                        cnt_nxt   = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_DELAY: begin
                // idx is stable here, so the ROM still presents this entry's delay.
                if (cnt == CNT_W'(entry_delay) - CNT_W'(1)) begin
                    advance = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (advance) begin
            cnt_nxt = '0;
            if (idx == LAST_IDX) begin
                state_nxt = ST_FINISH;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end else begin
                idx_nxt   = idx + IDX_W'(1);
                state_nxt = ST_LOAD;
            end
        end
    end

endmodule
